// File: rtl/divider_unsigned_iterative.sv
// Multi-cycle 32-bit unsigned restoring divider, BITS_PER_CYCLE quotient bits per clock.
// Optional DIVIDER_ZERO_FASTPATH_EN: a zero divisor skips BUSY and completes at acceptance.

module divider_cla32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    logic [31:0] g;
    logic [31:0] p;
    logic [32:0] c;
    logic [7:0]  gg;
    logic [7:0]  pg;

    // 4-bit groups: ripple inside a group, group generate/propagate between groups
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        gg   = '0;
        pg   = '0;
        c[0] = cin;
        for (int j = 0; j < 8; j++) begin
            gg[j] = g[4*j+3]
                  | (p[4*j+3] & g[4*j+2])
                  | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            pg[j] = &p[4*j +: 4];
            for (int k = 0; k < 3; k++) begin
                c[4*j+k+1] = g[4*j+k] | (p[4*j+k] & c[4*j+k]);
            end
            c[4*j+4] = gg[j] | (pg[j] & c[4*j]);
        end
        sum  = p ^ c[31:0];
        cout = c[32];
    end
endmodule

module divider_unsigned_iterative #(
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_quotient,
    output logic [31:0] o_remainder,
    output logic        o_busy
);
    localparam int unsigned ITERS = 32 / BITS_PER_CYCLE;
    localparam int unsigned CNT_W = $clog2(ITERS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      dvd_q, dvd_d;
    logic [31:0]      dvs_q, dvs_d;
    logic [31:0]      rem_q, rem_d;
    logic [31:0]      quo_res_q, quo_res_d;
    logic [31:0]      rem_res_q, rem_res_d;
    logic             ready_q, ready_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;

    // dvd shifts dividend bits out at the top and quotient bits in at the bottom
    logic [BITS_PER_CYCLE:0][31:0] rem_s;
    logic [BITS_PER_CYCLE:0][31:0] dvd_s;

    assign rem_s[0] = rem_q;
    assign dvd_s[0] = dvd_q;

    for (genvar k = 0; k < BITS_PER_CYCLE; k++) begin : g_step
        logic [32:0] r33;
        logic [31:0] diff;
        logic        cout;
        logic        ge;

        assign r33 = {rem_s[k], dvd_s[k][31]};
        divider_cla32 u_cla (
            .a   (r33[31:0]),
            .b   (~dvs_q),
            .cin (1'b1),
            .sum (diff),
            .cout(cout)
        );
        // carry out of a + ~b + 1 means a >= b; bit 32 covers divisors above 2^31
        assign ge           = r33[32] | cout;
        assign rem_s[k+1]   = ge ? diff : r33[31:0];
        assign dvd_s[k+1]   = {dvd_s[k][30:0], ge};
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        quo_res_d = quo_res_q;
        rem_res_d = rem_res_q;
        case (state_q)
            S_IDLE: begin
                if (i_valid && ready_q) begin
                    dvd_d   = i_dividend;
                    dvs_d   = i_divisor;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = S_BUSY;
`ifdef DIVIDER_ZERO_FASTPATH_EN
                    if (i_divisor == 32'd0) begin
                        state_d   = S_DONE;
                        quo_res_d = 32'hFFFF_FFFF;
                        rem_res_d = i_dividend;
                    end
`endif
                end
            end
            S_BUSY: begin
                dvd_d = dvd_s[BITS_PER_CYCLE];
                rem_d = rem_s[BITS_PER_CYCLE];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ITERS - 1)) begin
                    state_d   = S_DONE;
                    quo_res_d = dvd_s[BITS_PER_CYCLE];
                    rem_res_d = rem_s[BITS_PER_CYCLE];
                end
            end
            S_DONE: begin
                if (i_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d == S_BUSY);
        valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            quo_res_q <= '0;
            rem_res_q <= '0;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            quo_res_q <= quo_res_d;
            rem_res_q <= rem_res_d;
            ready_q   <= ready_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
        end
    end

    assign o_ready     = ready_q;
    assign o_valid     = valid_q;
    assign o_busy      = busy_q;
    assign o_quotient  = quo_res_q;
    assign o_remainder = rem_res_q;
endmodule

// File: tb/tb_divider_unsigned_iterative.sv
// Scoreboard bench for divider_unsigned_iterative at BITS_PER_CYCLE = 1, 2 and 4.
module tb_divider_unsigned_iterative;
    logic        clk;
    logic        rst;
    logic        i_valid   [3];
    logic [31:0] i_dvd     [3];
    logic [31:0] i_dvs     [3];
    logic        i_rdy     [3];
    logic        o_rdy     [3];
    logic        o_vld     [3];
    logic        o_bsy     [3];
    logic [31:0] o_q       [3];
    logic [31:0] o_r       [3];

    int          total = 0;
    int          bad   = 0;
    logic [63:0] sb [$];
    logic [63:0] last_exp;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        divider_unsigned_iterative #(.BITS_PER_CYCLE(1 << g)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .i_valid    (i_valid[g]),
            .o_ready    (o_rdy[g]),
            .i_dividend (i_dvd[g]),
            .i_divisor  (i_dvs[g]),
            .o_valid    (o_vld[g]),
            .i_ready    (i_rdy[g]),
            .o_quotient (o_q[g]),
            .o_remainder(o_r[g]),
            .o_busy     (o_bsy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        return {a / b, a % b};
    endfunction

    function automatic bit is_fast(input logic [31:0] b);
`ifdef DIVIDER_ZERO_FASTPATH_EN
        return (b == 32'd0);
`else
        return 1'b0;
`endif
    endfunction

    // Accept one operation, measure latency, compare result, optionally hand it off
    task automatic run_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                          input bit handoff);
        int          wt;
        int          lat;
        int          exp_lat;
        logic [63:0] e;
        wt = 0;
        while (!o_rdy[idx] && wt < 100) begin
            step();
            wt++;
        end
        chk($sformatf("rdy_wait%0d", idx), 64'(wt < 100), 64'd1);
        sb.push_back(model(a, b));
        i_valid[idx] = 1'b1;
        i_dvd[idx]   = a;
        i_dvs[idx]   = b;
        step();
        i_valid[idx] = 1'b0;
        chk($sformatf("accept%0d", idx), 64'({o_rdy[idx], o_vld[idx], o_bsy[idx]}),
            is_fast(b) ? 64'b010 : 64'b001);
        exp_lat = is_fast(b) ? 0 : (32 >> idx);
        lat = 0;
        while (!o_vld[idx] && lat < 100) begin
            step();
            lat++;
        end
        chk($sformatf("lat%0d_%h_%h", idx, a, b), 64'(lat), 64'(exp_lat));
        if (sb.size() == 0) begin
            chk("sb_empty", 64'd0, 64'd1);
            e = '0;
        end else begin
            e = sb.pop_front();
        end
        last_exp = e;
        chk($sformatf("res%0d_%h_%h", idx, a, b), {o_q[idx], o_r[idx]}, e);
        if (handoff) begin
            i_rdy[idx] = 1'b1;
            step();
            i_rdy[idx] = 1'b0;
            chk($sformatf("handoff%0d", idx), 64'({o_rdy[idx], o_vld[idx], o_bsy[idx]}), 64'b100);
            chk($sformatf("keep%0d", idx), {o_q[idx], o_r[idx]}, e);
        end
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        for (int i = 0; i < 3; i++) begin
            i_valid[i] = 1'b0;
            i_dvd[i]   = '0;
            i_dvs[i]   = '0;
            i_rdy[i]   = 1'b0;
        end
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset%0d", i),
                {29'd0, o_rdy[i], o_vld[i], o_bsy[i], 32'd0} | 64'(o_q[i] | o_r[i]),
                {29'd0, 3'b100, 32'd0});
        end

        // single-bit datapath: directed corners then random
        run_op(0, 32'd100, 32'd7, 1);
        run_op(0, 32'hFFFF_FFFF, 32'h8000_0001, 1);
        run_op(0, 32'h1234, 32'd0, 1);
        run_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        run_op(0, 32'd5, 32'd10, 1);
        run_op(0, 32'h8000_0000, 32'd1, 1);
        for (int n = 0; n < 6; n++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            run_op(0, ra, rb, 1);
        end

        // result held in DONE while the upstream side toggles
        run_op(0, 32'd1000, 32'd33, 0);
        for (int n = 0; n < 10; n++) begin
            i_valid[0] = 1'($urandom);
            i_dvd[0]   = $urandom;
            i_dvs[0]   = $urandom;
            step();
            chk("hold_res", {o_q[0], o_r[0]}, last_exp);
            chk("hold_ctl", 64'({o_rdy[0], o_vld[0], o_bsy[0]}), 64'b010);
        end
        i_valid[0] = 1'b1;
        i_dvd[0]   = 32'd50;
        i_dvs[0]   = 32'd5;
        i_rdy[0]   = 1'b1;
        step();
        i_rdy[0] = 1'b0;
        chk("handoff_only", 64'({o_rdy[0], o_vld[0], o_bsy[0]}), 64'b100);
        chk("handoff_keep", {o_q[0], o_r[0]}, last_exp);
        step();
        i_valid[0] = 1'b0;
        chk("accept_after", 64'({o_rdy[0], o_vld[0], o_bsy[0]}), 64'b001);

        // reset ten cycles into BUSY drops the operation
        repeat (9) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_reset", {29'd0, o_rdy[0], o_vld[0], o_bsy[0]} | 64'(o_q[0] | o_r[0]), 64'b100);
        repeat (40) step();
        chk("no_stale", 64'(o_vld[0]), 64'd0);
        run_op(0, 32'd9, 32'd3, 1);

        // multi-bit datapaths
        for (int i = 1; i < 3; i++) begin
            run_op(i, 32'hDEAD_BEEF, 32'h1000, 1);
            run_op(i, 32'hFFFF_FFFF, 32'h8000_0001, 1);
            run_op(i, 32'h1234, 32'd0, 1);
            run_op(i, 32'd100, 32'd7, 1);
            for (int n = 0; n < 4; n++) begin
                ra = $urandom;
                rb = $urandom >> $urandom_range(0, 31);
                run_op(i, ra, rb, 1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
